// File: rtl/bcd_stopwatch_multi_if.sv
// Control and display bundle of the multi-digit BCD stopwatch.
// master drives the commands, slave is the stopwatch itself.
interface bcd_stopwatch_multi_if #(
    parameter int DIGITS = 4
);
    logic                  start_resume;
    logic                  stop;
    logic                  clear;
    logic                  lap;
    logic [4*DIGITS-1:0]   number;
    logic                  running;
    logic                  lap_active;
    logic                  overflow;

    modport master (
        output start_resume, stop, clear, lap,
        input  number, running, lap_active, overflow
    );

    modport slave (
        input  start_resume, stop, clear, lap,
        output number, running, lap_active, overflow
    );
endinterface

// File: rtl/bcd_stopwatch_multi.sv
// N-digit BCD stopwatch with tick prescaler, lap freeze,
// synchronous clear and wrap/saturate overflow policy.
module bcd_stopwatch_multi #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1,
    parameter int WRAP     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_stopwatch_multi_if.slave  sw
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int NW = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_presc;
    logic [NW-1:0]   r_count;
    logic [NW-1:0]   r_lap;
    logic            r_lap_active;
    logic            r_overflow;
    logic            r_running;
    logic            r_lap_q;
    logic [NW-1:0]   w_inc;
    logic            w_all9;
    logic            w_presc_end;
    logic            w_tick;
    logic            w_lap_rise;

    assign w_presc_end = (r_presc == PW'(TICK_DIV - 1));
    assign w_tick      = (r_state == S_RUN) && w_presc_end && !sw.clear;
    assign w_lap_rise  = sw.lap && !r_lap_q;

    // Ripple BCD increment; a carry surviving every digit means all-9s.
    always_comb begin
        logic c;
        c     = 1'b1;
        w_inc = r_count;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        w_all9 = c;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (sw.clear) begin
            w_state_nxt = S_IDLE;
        end else if (sw.stop) begin
            if (r_state == S_RUN) w_state_nxt = S_PAUSE;
        end else if (sw.start_resume) begin
            w_state_nxt = S_RUN;
        end
        if (w_tick && w_all9 && (WRAP == 0)) begin
            w_state_nxt = S_PAUSE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_running    <= 1'b0;
            r_presc      <= '0;
            r_count      <= '0;
            r_lap        <= '0;
            r_lap_active <= 1'b0;
            r_overflow   <= 1'b0;
            r_lap_q      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_lap_q   <= sw.lap;
            if (sw.clear) begin
                r_presc      <= '0;
                r_count      <= '0;
                r_lap        <= '0;
                r_lap_active <= 1'b0;
                r_overflow   <= 1'b0;
            end else begin
                if (r_state == S_RUN) begin
                    r_presc <= w_presc_end ? '0 : r_presc + PW'(1);
                end
                if (w_tick) begin
                    r_overflow <= r_overflow | w_all9;
                    if (!w_all9) begin
                        r_count <= w_inc;
                    end else if (WRAP != 0) begin
                        r_count <= '0;
                    end
                end
                if (w_lap_rise) begin
                    if (r_lap_active) begin
                        r_lap_active <= 1'b0;
                    end else if (r_state == S_RUN) begin
                        r_lap_active <= 1'b1;
                        r_lap        <= r_count;
                    end
                end
            end
        end
    end

    assign sw.number     = r_lap_active ? r_lap : r_count;
    assign sw.running    = r_running;
    assign sw.lap_active = r_lap_active;
    assign sw.overflow   = r_overflow;
endmodule
